reg_dump_unit: RTL and testbench
================================

# reg_dump_unit

Sequential read-side companion to the register file. On a start pulse it walks a contiguous range of registers through one register-file read port and streams each 32-bit word out as four bytes, MSB first, over a valid/ready byte interface. It sits between the register-file read port and a debug/transmit path (e.g. a UART TX), giving a hardware register dump.

## Interface
Parameters:
- FIRST_REG, 0, first register index dumped (0..31)
- LAST_REG, 31, last register index dumped (FIRST_REG..31)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- abort  in  1  synchronous cancel; honoured in any busy state
- rd_addr  out  5  register index to the register-file read port
- rd_data  in  32  combinational read data for rd_addr
- out_data  out  8  current byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts the byte this cycle
- busy  out  1  high in LOAD and SEND
- done  out  1  one-cycle pulse when the last byte has been accepted

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: start=1 -> LOAD, index <= FIRST_REG, byte_cnt <= 0.
- LOAD: rd_addr = index; shift register <= rd_data at the clock edge; -> SEND.
- SEND: out_valid=1, out_data = shift[31:24]. On out_valid&out_ready: shift <= shift << 8, byte_cnt++. When the 4th byte (byte_cnt==3) is accepted:
  - index==LAST_REG -> DONE;
  - otherwise index++ and -> LOAD.
- DONE: done=1 for one cycle -> IDLE.
- abort=1 in LOAD or SEND -> IDLE next edge, no done pulse, and no further bytes. A byte whose handshake completes in the same cycle as abort counts as accepted.
- start while busy or in DONE: ignored.
- rd_addr = index in all states. It holds its last value in IDLE and is FIRST_REG after reset.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake, except on abort or reset.
- index is 5 bits and never wraps: LAST_REG=31 terminates without incrementing past 31.

## Timing
- Reset values:
  - state=IDLE
  - out_valid=0, out_data=0, busy=0, done=0
  - rd_addr=FIRST_REG, internal shift=0, byte_cnt=0
- start sampled at edge N:
  - LOAD during cycle N+1;
  - first out_valid in cycle N+2.
- Each register costs 1 LOAD cycle plus 4 SEND handshakes.
- With out_ready tied high, full default dump:
  - 32×5 = 160 busy cycles;
  - done asserted in cycle N+161.
- Back-pressure stretches only SEND. LOAD is always one cycle.
- rd_data must be valid combinationally within the LOAD cycle; the block does no re-read.
- Reset asserted mid-dump: outputs go to reset values immediately (asynchronous), with no pulse on done.

## Structure
- Shared package holds:
  - state encodings (IDLE/LOAD/SEND/DONE, 2 bits);
  - BYTES_PER_WORD=4;
  - REG_ADDR_W=5;
  - DATA_W=32.
- One natural sub-module: word_byte_serializer. It takes a 32-bit parallel load plus a valid/ready byte output with a 2-bit byte counter, and reports last_byte_accepted. The top level keeps the FSM and the index counter.

## Test plan
- Default params, out_ready=1, registers preloaded with reg[i]=0x01020300+i, start pulse:
  - byte stream 01 02 03 00, 01 02 03 01, … 01 02 03 1F (128 bytes);
  - done exactly 161 cycles after start;
  - busy high 160 cycles.
- FIRST_REG=5, LAST_REG=5, reg5=0xDEADBEEF, out_ready toggling 1/0 each cycle:
  - bytes DE AD BE EF, each held stable while ready=0;
  - one done pulse.
- start re-pulsed during SEND and during DONE -> no restart, and the byte count stays 128.
- abort asserted while sending the 2nd byte of reg 3 (handshake completing that cycle):
  - that byte counts as accepted;
  - out_valid=0 next cycle;
  - no done pulse;
  - busy=0;
  - a new start dumps from FIRST_REG.
- Asynchronous reset mid-SEND (between edges) -> out_valid/busy drop immediately, with no done pulse. The next start gives a complete, correct dump.
- LAST_REG=31, out_ready=0 for 50 cycles in the final SEND, then 1:
  - index stays 31 with no wrap;
  - exactly 4 bytes for reg31;
  - a single done pulse.

Source files
------------

// File: rtl/reg_dump_unit_pkg.sv
// Shared types and constants for the register dump unit.
package reg_dump_unit_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned CNT_W          = 2;

  localparam logic [CNT_W-1:0] LAST_BYTE_IDX = CNT_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_unit_if.sv
// Valid/ready byte stream between the dump unit and its sink.
interface reg_dump_unit_if;
  import reg_dump_unit_pkg::*;

  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/reg_dump_unit_word_byte_serializer.sv
// Parallel-load 32-bit word, emitted MSB byte first over valid/ready.
module word_byte_serializer
  import reg_dump_unit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              clear_i,
  input  logic              send_i,
  input  logic              ready_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              valid_o,
  output logic              last_byte_accepted_o
);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fire;

  assign valid_o              = send_i;
  assign byte_o               = shift_q[DATA_W-1 -: BYTE_W];
  assign fire                 = send_i & ready_i;
  assign last_byte_accepted_o = fire && (cnt_q == LAST_BYTE_IDX);

  // Shift register and byte counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load wins; a cancel still lets an in-flight handshake shift out its byte.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = word_i;
      cnt_d   = '0;
    end else begin
      if (fire) begin
        shift_d = shift_q << BYTE_W;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      if (clear_i) begin
        cnt_d = '0;
      end
    end
  end

endmodule

// File: rtl/reg_dump_unit.sv
// Walks registers FIRST_REG..LAST_REG and streams each word as four bytes.
module reg_dump_unit
  import reg_dump_unit_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  done,
  reg_dump_unit_if.master       out_if
);

  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

  state_t                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   index_q, index_d;
  logic                    load_word;
  logic                    send_en;
  logic                    last_acc;

  assign rd_addr = index_q;

  word_byte_serializer u_ser (
    .clk_i                (clock),
    .rst_i                (reset),
    .load_i               (load_word),
    .word_i               (rd_data),
    .clear_i              (abort & busy),
    .send_i               (send_en),
    .ready_i              (out_if.out_ready),
    .byte_o               (out_if.out_data),
    .valid_o              (out_if.out_valid),
    .last_byte_accepted_o (last_acc)
  );

  // State and register index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Next state, index advance and control strobes.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    load_word = 1'b0;
    send_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          index_d = FIRST_IDX;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          load_word = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        busy    = 1'b1;
        send_en = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_acc) begin
          // Compare before incrementing so LAST_REG=31 never wraps to 0.
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            index_d = index_q + REG_ADDR_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: cycle table for a one-register dump,
// plus multi-cycle sequences on a full 0..31 dump.
module tb_reg_dump_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance with a modelled register file.
  logic        start0, abort0, busy0, done0;
  logic [4:0]  addr0;
  logic [31:0] rdat0;
  reg_dump_unit_if if0();
  assign rdat0 = 32'h0102_0300 + {27'd0, addr0};

  reg_dump_unit dut0 (
    .clock(clk), .reset(rst), .start(start0), .abort(abort0),
    .rd_addr(addr0), .rd_data(rdat0), .busy(busy0), .done(done0),
    .out_if(if0)
  );

  // Single-register instance.
  logic        start1, abort1, busy1, done1;
  logic [4:0]  addr1;
  logic [31:0] rdat1;
  reg_dump_unit_if if1();
  assign rdat1 = (addr1 == 5'd5) ? 32'hDEAD_BEEF : 32'h0;

  reg_dump_unit #(.FIRST_REG(5), .LAST_REG(5)) dut1 (
    .clock(clk), .reset(rst), .start(start1), .abort(abort1),
    .rd_addr(addr1), .rd_data(rdat1), .busy(busy1), .done(done1),
    .out_if(if1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic [4:0] addr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic a, input logic r, input logic v,
                              input logic [7:0] d, input logic b, input logic dn,
                              input logic [4:0] ad);
    vec_t t;
    t.start = s; t.abort = a; t.ready = r; t.valid = v;
    t.data = d; t.busy = b; t.done = dn; t.addr = ad;
    return t;
  endfunction

  // Observations gathered by run_dump.
  logic [7:0] bytes[$];
  int busy_cnt, done_cnt, done_cyc, stall_bad, v_after_abort;

  task automatic run_dump(input int nsteps, input int stall_from, input int stall_len,
                          input int abort_at, input int rep_a, input int rep_b,
                          input logic [7:0] s_data, input logic [4:0] s_addr);
    bytes.delete();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; stall_bad = 0; v_after_abort = 0;
    for (int k = 0; k < nsteps; k++) begin
      start0 = (k == 0) || (k == rep_a) || (k == rep_b);
      abort0 = (k == abort_at);
      if0.out_ready = !((k >= stall_from) && (k < stall_from + stall_len));
      #1;
      if (if0.out_valid && if0.out_ready) bytes.push_back(if0.out_data);
      if (busy0) busy_cnt++;
      if (done0) begin done_cnt++; done_cyc = k; end
      if ((abort_at >= 0) && (k > abort_at) && if0.out_valid) v_after_abort++;
      if ((k >= stall_from) && (k < stall_from + stall_len))
        if (!if0.out_valid || if0.out_data !== s_data || addr0 !== s_addr) stall_bad++;
      @(posedge clk); #1;
    end
    start0 = 1'b0; abort0 = 1'b0; if0.out_ready = 1'b1;
  endtask

  task automatic check_full(input string tag, input int exp_done_cyc, input int exp_busy);
    logic [31:0] w;
    logic [7:0]  eb;
    chk({tag, "_nbytes"}, bytes.size(), 128);
    if (bytes.size() == 128) begin
      for (int i = 0; i < 128; i++) begin
        w  = 32'h0102_0300 + 32'(i / 4);
        eb = w[31 - 8*(i % 4) -: 8];
        chk($sformatf("%s_byte%0d", tag, i), {24'd0, bytes[i]}, {24'd0, eb});
      end
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, exp_done_cyc);
    chk({tag, "_busy_cnt"}, busy_cnt, exp_busy);
  endtask

  vec_t tbl[13];

  initial begin
    rst = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; if0.out_ready = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; if1.out_ready = 1'b0;

    #2;
    chk("rst_valid", {31'd0, if0.out_valid}, 0);
    chk("rst_data",  {24'd0, if0.out_data}, 0);
    chk("rst_busy",  {31'd0, busy0}, 0);
    chk("rst_done",  {31'd0, done0}, 0);
    chk("rst_addr0", {27'd0, addr0}, 0);
    chk("rst_addr1", {27'd0, addr1}, 5);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Single register 5, ready toggling; start in SEND (row 4) and DONE (row 10) ignored.
    tbl[0]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 5);
    tbl[1]  = mk(0, 0, 1, 0, 8'h00, 1, 0, 5);
    tbl[2]  = mk(0, 0, 0, 1, 8'hDE, 1, 0, 5);
    tbl[3]  = mk(0, 0, 1, 1, 8'hDE, 1, 0, 5);
    tbl[4]  = mk(1, 0, 0, 1, 8'hAD, 1, 0, 5);
    tbl[5]  = mk(0, 0, 1, 1, 8'hAD, 1, 0, 5);
    tbl[6]  = mk(0, 0, 0, 1, 8'hBE, 1, 0, 5);
    tbl[7]  = mk(0, 0, 1, 1, 8'hBE, 1, 0, 5);
    tbl[8]  = mk(0, 0, 0, 1, 8'hEF, 1, 0, 5);
    tbl[9]  = mk(0, 0, 1, 1, 8'hEF, 1, 0, 5);
    tbl[10] = mk(1, 0, 0, 0, 8'h00, 0, 1, 5);
    tbl[11] = mk(0, 0, 0, 0, 8'h00, 0, 0, 5);
    tbl[12] = mk(0, 0, 0, 0, 8'h00, 0, 0, 5);
    for (int i = 0; i < 13; i++) begin
      start1 = tbl[i].start; abort1 = tbl[i].abort; if1.out_ready = tbl[i].ready;
      #1;
      chk($sformatf("t%0d_valid", i), {31'd0, if1.out_valid}, {31'd0, tbl[i].valid});
      chk($sformatf("t%0d_data", i),  {24'd0, if1.out_data},  {24'd0, tbl[i].data});
      chk($sformatf("t%0d_busy", i),  {31'd0, busy1},         {31'd0, tbl[i].busy});
      chk($sformatf("t%0d_done", i),  {31'd0, done1},         {31'd0, tbl[i].done});
      chk($sformatf("t%0d_addr", i),  {27'd0, addr1},         {27'd0, tbl[i].addr});
      @(posedge clk); #1;
    end
    start1 = 1'b0;

    // Full dump, ready high, start re-pulsed in SEND (step 50) and in DONE (step 161).
    run_dump(170, -1, 0, -1, 50, 161, 8'h00, 5'd0);
    check_full("full", 161, 160);

    // Abort on the 2nd byte of reg 3 (step 18) with its handshake completing.
    run_dump(25, -1, 0, 18, -1, -1, 8'h00, 5'd0);
    chk("abort_nbytes", bytes.size(), 14);
    if (bytes.size() == 14) begin
      chk("abort_last_byte", {24'd0, bytes[13]}, 32'h02);
      chk("abort_prev_byte", {24'd0, bytes[12]}, 32'h01);
    end
    chk("abort_valid_after", v_after_abort, 0);
    chk("abort_busy_cnt", busy_cnt, 18);
    chk("abort_done_cnt", done_cnt, 0);
    run_dump(170, -1, 0, -1, -1, -1, 8'h00, 5'd0);
    check_full("after_abort", 161, 160);

    // Asynchronous reset between edges during SEND of reg 1.
    run_dump(8, -1, 0, -1, -1, -1, 8'h00, 5'd0);
    chk("pre_rst_valid", {31'd0, if0.out_valid}, 1);
    chk("pre_rst_addr",  {27'd0, addr0}, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, if0.out_valid}, 0);
    chk("arst_busy",  {31'd0, busy0}, 0);
    chk("arst_done",  {31'd0, done0}, 0);
    chk("arst_data",  {24'd0, if0.out_data}, 0);
    chk("arst_addr",  {27'd0, addr0}, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_dump(170, -1, 0, -1, -1, -1, 8'h00, 5'd0);
    check_full("after_rst", 161, 160);

    // 50-cycle stall on the first byte of reg 31.
    run_dump(220, 157, 50, -1, -1, -1, 8'h01, 5'd31);
    check_full("stall31", 211, 210);
    chk("stall31_stable", stall_bad, 0);
    chk("stall31_idle_addr", {27'd0, addr0}, 31);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
